featuremap_channel_accum: RTL and testbench

- Parametrised successor to the fixed 8-channel bias-adder stage of a conv feature-map filter.
- Sums NUM_CH per-channel FP32 3x3-conv results for one output pixel and adds a per-filter bias.
- The sum runs serially on one shared FP32 adder instead of an adder tree; adds valid/ready backpressure and row/column position tracking.
- Sits between the per-channel conv2D engines and the next layer's line buffer/FIFO.

---
 rtl/featuremap_pkg.sv | 21 ++
 rtl/featuremap_channel_accum_if.sv | 28 ++
 rtl/fp32_add.sv | 104 ++++++++++
 rtl/featuremap_channel_accum.sv | 131 +++++++++++++
 tb/tb_featuremap_channel_accum.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/featuremap_pkg.sv
// Shared definitions for the feature-map channel accumulator.
// Holds the FP32 field widths, the special-value constants and the
// controller state type. Imported by fp32_add and featuremap_channel_accum.
package featuremap_pkg;

   localparam int unsigned EXP_W    = 8;
   localparam int unsigned MAN_W    = 23;
   localparam int unsigned EXP_BIAS = 127;

   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StBias,
      StOut
   } state_t;

endpackage

// File: rtl/featuremap_channel_accum_if.sv
// Streaming bus of the channel accumulator.
//   in_valid/in_ready/in_data : one pixel's NUM_CH conv results (ch c at [c*32 +: 32])
//   out_valid/out_ready/out_data : channel sum plus bias
//   out_last_col/out_last_frame  : position flags of the current output
// slave is the accumulator side, master is the producer/consumer side.
interface featuremap_channel_accum_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_CH     = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic [NUM_CH*DATA_WIDTH-1:0] in_data;
   logic                         out_valid;
   logic                         out_ready;
   logic [DATA_WIDTH-1:0]        out_data;
   logic                         out_last_col;
   logic                         out_last_frame;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last_col, out_last_frame
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last_col, out_last_frame
   );
endinterface

// File: rtl/fp32_add.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Denormal inputs count as zero, results below the smallest normal become +0,
// overflow gives signed Inf, exact cancellation gives +0, any NaN gives a quiet NaN.
//   a_i, b_i : operands
//   sum_o    : a_i + b_i
module fp32_add
   import featuremap_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] sum_o
);

   logic             sa, sb, s_big, swap, found, round_up;
   logic [EXP_W-1:0] ea, eb, e_big, e_small, diff;
   logic [MAN_W-1:0] ma, mb, frac;
   logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [26:0]      m_big, m_small, m_align, norm;
   logic [27:0]      raw;
   logic [4:0]       lz;
   logic [24:0]      mant;
   logic signed [9:0] exp_n, exp_r;
   logic [31:0]      norm_res;

   always_comb begin
      {sa, ea, ma} = a_i;
      {sb, eb, mb} = b_i;
      a_nan  = (ea == '1) && (ma != '0);
      b_nan  = (eb == '1) && (mb != '0);
      a_inf  = (ea == '1) && (ma == '0);
      b_inf  = (eb == '1) && (mb == '0);
      a_zero = (ea == '0);
      b_zero = (eb == '0);

      // Order by magnitude so the subtraction below never goes negative.
      swap    = {eb, mb} > {ea, ma};
      s_big   = swap ? sb : sa;
      e_big   = swap ? eb : ea;
      e_small = swap ? ea : eb;
      m_big   = {1'b1, swap ? mb : ma, 3'b000};
      m_small = {1'b1, swap ? ma : mb, 3'b000};
      diff    = e_big - e_small;

      // Align with guard/round bits; everything shifted out folds into the sticky LSB.
      if (diff >= 8'd27) begin
         m_align = 27'd1;
      end else begin
         m_align = m_small >> diff;
         if ((m_small & ~({27{1'b1}} << diff)) != '0) m_align[0] = 1'b1;
      end

      raw = (sa ^ sb) ? ({1'b0, m_big} - {1'b0, m_align})
                      : ({1'b0, m_big} + {1'b0, m_align});

      lz    = '0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && raw[i]) begin
            lz    = 5'(26 - i);
            found = 1'b1;
         end
      end

      if (raw[27]) begin
         norm  = raw[27:1] | {26'd0, raw[0]};
         exp_n = $signed({2'b00, e_big}) + 10'sd1;
      end else begin
         norm  = raw[26:0] << lz;
         exp_n = $signed({2'b00, e_big}) - $signed({5'd0, lz});
      end

      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant     = {1'b0, norm[26:3]} + {24'd0, round_up};
      exp_r    = mant[24] ? exp_n + 10'sd1 : exp_n;
      frac     = mant[24] ? mant[23:1] : mant[22:0];

      if (raw == '0 || exp_r <= 10'sd0) begin
         norm_res = FP_POS_ZERO;
      end else if (exp_r >= 10'sd255) begin
         norm_res = FP_POS_INF | {s_big, 31'd0};
      end else begin
         norm_res = {s_big, exp_r[7:0], frac};
      end

      if (a_nan || b_nan) begin
         sum_o = FP_QNAN;
      end else if (a_inf && b_inf) begin
         sum_o = (sa != sb) ? FP_QNAN : (FP_POS_INF | {sa, 31'd0});
      end else if (a_inf) begin
         sum_o = FP_POS_INF | {sa, 31'd0};
      end else if (b_inf) begin
         sum_o = FP_POS_INF | {sb, 31'd0};
      end else if (a_zero && b_zero) begin
         sum_o = {sa & sb, 31'd0};
      end else if (a_zero) begin
         sum_o = b_i;
      end else if (b_zero) begin
         sum_o = a_i;
      end else begin
         sum_o = norm_res;
      end
   end

endmodule

// File: rtl/featuremap_channel_accum.sv
// Sums NUM_CH FP32 channel results of one output pixel on a single shared
// adder, adds BIAS and emits the result with row/column position flags.
//   clk, rst : clock, synchronous active-high reset
//   bus      : featuremap_channel_accum_if.slave (input pixel stream, output stream)
// Build option FEATUREMAP_RELU_EN: negative results (sign bit set) are output as +0.
module featuremap_channel_accum
   import featuremap_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_CH     = 8,
   parameter logic [31:0] BIAS       = 32'h0000_0000,
   parameter int unsigned WIDTH      = 112,
   parameter int unsigned HEIGHT     = 112
) (
   input logic                       clk,
   input logic                       rst,
   featuremap_channel_accum_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   state_t                       state_q, state_d;
   logic [NUM_CH*DATA_WIDTH-1:0] vec_q, vec_d;
   logic [DATA_WIDTH-1:0]        acc_q, acc_d, out_data_q, out_data_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [COL_W-1:0]             col_q, col_d;
   logic [ROW_W-1:0]             row_q, row_d;
   logic                         valid_q, valid_d;
   logic                         in_ready, accept, handshake, last_col;
   logic [DATA_WIDTH-1:0]        add_b, add_sum, bias_res;

   fp32_add u_add (
      .a_i   (acc_q),
      .b_i   (add_b),
      .sum_o (add_sum)
   );

   assign add_b = (state_q == StBias) ? BIAS : vec_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

`ifdef FEATUREMAP_RELU_EN
   assign bias_res = add_sum[DATA_WIDTH-1] ? FP_POS_ZERO : add_sum;
`else
   assign bias_res = add_sum;
`endif

   assign in_ready  = (state_q == StIdle) || (state_q == StOut && bus.out_ready);
   assign accept    = bus.in_valid && in_ready;
   assign handshake = valid_q && bus.out_ready;
   assign last_col  = (col_q == COL_W'(WIDTH - 1));

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = valid_q;
   assign bus.out_data       = out_data_q;
   assign bus.out_last_col   = valid_q && last_col;
   assign bus.out_last_frame = valid_q && last_col && (row_q == ROW_W'(HEIGHT - 1));

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      out_data_d = out_data_q;
      valid_d    = valid_q;
      col_d      = col_q;
      row_d      = row_q;

      unique case (state_q)
         StIdle: ;
         StAccum: begin
            acc_d = add_sum;
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(NUM_CH - 1)) state_d = StBias;
         end
         StBias: begin
            acc_d      = add_sum;
            out_data_d = bias_res;
            valid_d    = 1'b1;
            state_d    = StOut;
         end
         StOut: begin
            if (handshake) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Accept in StOut coincides with the output handshake, so it overrides the IDLE move.
      if (accept) begin
         vec_d   = bus.in_data;
         acc_d   = bus.in_data[DATA_WIDTH-1:0];
         idx_d   = IDX_W'(1);
         state_d = (NUM_CH > 1) ? StAccum : StBias;
      end

      if (handshake) begin
         if (last_col) begin
            col_d = '0;
            row_d = (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         vec_q      <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         out_data_q <= '0;
         valid_q    <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         out_data_q <= out_data_d;
         valid_q    <= valid_d;
         col_q      <= col_d;
         row_q      <= row_d;
      end
   end

endmodule

// File: tb/tb_featuremap_channel_accum.sv
// Directed bench for featuremap_channel_accum. dut_a: NUM_CH=8, BIAS=-1.0, 4x2 frame.
// dut_b: NUM_CH=8, BIAS=0, default frame size.
module tb_featuremap_channel_accum;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   featuremap_channel_accum_if #(.DATA_WIDTH(32), .NUM_CH(8)) bus_a ();
   featuremap_channel_accum_if #(.DATA_WIDTH(32), .NUM_CH(8)) bus_b ();

   featuremap_channel_accum #(
      .DATA_WIDTH (32),
      .NUM_CH     (8),
      .BIAS       (32'hBF80_0000),
      .WIDTH      (4),
      .HEIGHT     (2)
   ) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   featuremap_channel_accum #(
      .DATA_WIDTH (32),
      .NUM_CH     (8),
      .BIAS       (32'h0000_0000),
      .WIDTH      (112),
      .HEIGHT     (112)
   ) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

`ifdef FEATUREMAP_RELU_EN
   localparam logic [31:0] EXP_NEG3 = 32'h0000_0000;
`else
   localparam logic [31:0] EXP_NEG3 = 32'hC040_0000;
`endif

   int n_cmp = 0;
   int n_fail = 0;
   int hs_a = 0, acc_a = 0, hs_b = 0;
   int pos_n = 0;
   bit pos_rec = 1'b0;
   logic lc [16];
   logic lf [16];

   // Inputs only change #1 after posedge, so negedge values are what the next edge sees.
   always @(negedge clk) begin
      if (!rst_a) begin
         if (bus_a.in_valid && bus_a.in_ready) acc_a++;
         if (bus_a.out_valid && bus_a.out_ready) begin
            hs_a++;
            if (pos_rec && pos_n < 16) begin
               lc[pos_n] = bus_a.out_last_col;
               lf[pos_n] = bus_a.out_last_frame;
               pos_n++;
            end
         end
      end
      if (!rst_b && bus_b.out_valid && bus_b.out_ready) hs_b++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One pixel through dut_b from IDLE; returns the output word.
   task automatic run_b(input logic [255:0] d, output logic [31:0] r);
      int cyc;
      bus_b.in_data  = d;
      bus_b.in_valid = 1'b1;
      @(posedge clk);
      #1 bus_b.in_valid = 1'b0;
      cyc = 0;
      while (!bus_b.out_valid && cyc < 40) begin
         @(posedge clk);
         #1 cyc++;
      end
      check("run_b_valid", {31'd0, bus_b.out_valid}, 32'd1);
      r = bus_b.out_data;
      bus_b.out_ready = 1'b1;
      @(posedge clk);
      #1 bus_b.out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, cyc, h0, a0;
      logic [31:0] r;

      bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.in_data = '0;
      bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.in_data = '0;
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b0; rst_b = 1'b0;

      check("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
      check("rst_out_data", bus_a.out_data, 32'd0);
      check("rst_last_col", {31'd0, bus_a.out_last_col}, 32'd0);
      check("rst_last_frame", {31'd0, bus_a.out_last_frame}, 32'd0);
      check("rst_b_out_valid", {31'd0, bus_b.out_valid}, 32'd0);

      // 8 x 1.0 - 1.0 = 7.0; latency counted with the accepting edge as cycle 1.
      bus_a.in_data  = {8{32'h3F80_0000}};
      bus_a.in_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      #1 bus_a.in_valid = 1'b0;
      while (!bus_a.out_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      check("latency", lat, 32'd9);
      check("sum_7", bus_a.out_data, 32'h40E0_0000);
      check("first_last_col", {31'd0, bus_a.out_last_col}, 32'd0);

      // Backpressure: held for 5 cycles, then exactly one handshake.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_data", bus_a.out_data, 32'h40E0_0000);
         check("hold_valid", {31'd0, bus_a.out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
      end
      h0 = hs_a;
      bus_a.out_ready = 1'b1;
      @(posedge clk);
      #1 bus_a.out_ready = 1'b0;
      check("hs_valid_low", {31'd0, bus_a.out_valid}, 32'd0);
      check("hs_idle_ready", {31'd0, bus_a.in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1 check("hs_once", hs_a - h0, 32'd1);

      // Back-to-back: handshakes at accept-edge +9, +18, +27, +36.
      h0 = hs_a;
      a0 = acc_a;
      bus_a.in_valid  = 1'b1;
      bus_a.out_ready = 1'b1;
      @(posedge clk);
      repeat (35) @(posedge clk);
      #1 check("b2b_hs_35", hs_a - h0, 32'd3);
      @(posedge clk);
      #1;
      check("b2b_hs_36", hs_a - h0, 32'd4);
      check("b2b_accepts", acc_a - a0, 32'd5);
      bus_a.in_valid = 1'b0;
      cyc = 0;
      while (hs_a - h0 < 5 && cyc < 20) begin
         @(posedge clk);
         #1 cyc++;
      end
      check("b2b_drain", hs_a - h0, 32'd5);
      bus_a.out_ready = 1'b0;

      // Position flags on a fresh 4x2 frame, 9 outputs.
      rst_a = 1'b1;
      @(posedge clk);
      #1 rst_a = 1'b0;
      pos_n = 0;
      pos_rec = 1'b1;
      bus_a.in_valid  = 1'b1;
      bus_a.out_ready = 1'b1;
      cyc = 0;
      while (pos_n < 9 && cyc < 150) begin
         @(posedge clk);
         #1 cyc++;
      end
      bus_a.in_valid = 1'b0;
      pos_rec = 1'b0;
      check("pos_count", pos_n, 32'd9);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("last_col_%0d", i + 1), {31'd0, lc[i]},
               (i == 3 || i == 7) ? 32'd1 : 32'd0);
         check($sformatf("last_frame_%0d", i + 1), {31'd0, lf[i]},
               (i == 7) ? 32'd1 : 32'd0);
      end
      repeat (12) @(posedge clk);
      #1 bus_a.out_ready = 1'b0;

      // Arithmetic on dut_b (BIAS = 0). Channel 0 is the rightmost word.
      // 1 - 2 + 0.5 - 2.5 + denormal + -0 + 0 + 0 = -3.0
      run_b({32'h0, 32'h0, 32'h8000_0000, 32'h0000_0001,
             32'hC020_0000, 32'h3F00_0000, 32'hC000_0000, 32'h3F80_0000}, r);
      check("sum_neg3", r, EXP_NEG3);
      // 1.0 + seven half-ulp ties: each rounds to even, stays 1.0
      run_b({{7{32'h3380_0000}}, 32'h3F80_0000}, r);
      check("rne_tie_even", r, 32'h3F80_0000);
      // (1 + 2^-23) + 2^-24: tie with odd LSB rounds up
      run_b({{6{32'h0}}, 32'h3380_0000, 32'h3F80_0001}, r);
      check("rne_tie_odd", r, 32'h3F80_0002);
      run_b({{6{32'h0}}, 32'h7F7F_FFFF, 32'h7F7F_FFFF}, r);
      check("overflow_inf", r, 32'h7F80_0000);
      run_b({{7{32'h0}}, 32'hFF80_0001}, r);
      check("nan_quiet", r, 32'h7FC0_0000);
      run_b({{6{32'h0}}, 32'hBF80_0000, 32'h3F80_0000}, r);
      check("cancel_pos_zero", r, 32'h0000_0000);
      run_b({{6{32'h0}}, 32'h0080_0000, 32'h8080_0001}, r);
      check("underflow_flush", r, 32'h0000_0000);

      // Reset while in ACCUM with idx = 3: pixel is dropped.
      h0 = hs_b;
      bus_b.in_data  = {8{32'h4000_0000}};
      bus_b.in_valid = 1'b1;
      @(posedge clk);
      #1 bus_b.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_b = 1'b1;
      @(posedge clk);
      #1 rst_b = 1'b0;
      check("mid_rst_valid", {31'd0, bus_b.out_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, bus_b.in_ready}, 32'd1);
      run_b({8{32'h4000_0000}}, r);
      check("after_rst_16", r, 32'h4180_0000);
      repeat (12) @(posedge clk);
      #1 check("after_rst_hs", hs_b - h0, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
